ex_stage: RTL and testbench

Execute pipeline stage of the rv32i core. It accepts one decoded instruction per cycle from the decode stage over a valid/ready handshake, selects and forwards operands, and computes the result through `adder_sub` plus a small logic/compare unit. The result is registered into a single output slot that the memory stage drains over its own valid/ready handshake.

---
 rtl/rv32i_pkg.sv | 24 ++
 rtl/adder_sub.sv | 25 ++
 rtl/fwd_mux.sv | 29 ++
 rtl/ex_stage.sv | 126 ++++++++++++
 tb/tb_ex_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i core: datapath widths, ALU opcodes
// and operand-select encodings.
package rv32i_pkg;

  localparam int unsigned DPW = 32;
  localparam int unsigned RAW = 5;

  // 4-bit code leaves room for unused encodings, which the ALU turns into 0
  typedef enum logic [3:0] {
    ADD_OP  = 4'd0,
    SUB_OP  = 4'd1,
    SLT_OP  = 4'd2,
    SLTU_OP = 4'd3,
    AND_OP  = 4'd4,
    OR_OP   = 4'd5,
    XOR_OP  = 4'd6
  } alu_op_t;

  localparam logic A_SEL_RS1 = 1'b0;
  localparam logic A_SEL_PC  = 1'b1;
  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

endpackage

// File: rtl/adder_sub.sv
// Shared adder/subtractor; also exposes carry-out and signed overflow so the
// compare ops can be derived from the difference.
module adder_sub
  import rv32i_pkg::*;
(
  input  alu_op_t        op,
  input  logic [DPW-1:0] a,
  input  logic [DPW-1:0] b,
  output logic [DPW-1:0] sum,
  output logic           cout,
  output logic           ovf
);

  logic           sub;
  logic [DPW-1:0] b_eff;
  logic [DPW:0]   full;

  assign sub   = (op == SUB_OP);
  assign b_eff = sub ? ~b : b;
  assign full  = {1'b0, a} + {1'b0, b_eff} + {{DPW{1'b0}}, sub};
  assign sum   = full[DPW-1:0];
  assign cout  = full[DPW];
  assign ovf   = (a[DPW-1] == b_eff[DPW-1]) && (sum[DPW-1] != a[DPW-1]);

endmodule

// File: rtl/fwd_mux.sv
// Priority operand forwarding for one source register: mem beats wb beats
// the register-file value; x0 always reads as zero.
module fwd_mux
  import rv32i_pkg::*;
(
  input  logic [RAW-1:0] addr,
  input  logic [DPW-1:0] id_data,
  input  logic           mem_wen,
  input  logic [RAW-1:0] mem_addr,
  input  logic [DPW-1:0] mem_data,
  input  logic           wb_wen,
  input  logic [RAW-1:0] wb_addr,
  input  logic [DPW-1:0] wb_data,
  output logic [DPW-1:0] data
);

  logic addr_nz;
  assign addr_nz = (addr != '0);

  always_comb begin
    data = '0;
    if (addr_nz) begin
      if (mem_wen && (mem_addr == addr))     data = mem_data;
      else if (wb_wen && (wb_addr == addr))  data = wb_data;
      else                                   data = id_data;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwards and selects operands, computes the ALU result and
// holds it in a single valid/ready output slot for the memory stage.
module ex_stage
  import rv32i_pkg::*;
(
  input  logic           clk,
  input  logic           arst,
  input  logic           id_valid,
  output logic           id_ready,
  input  logic [DPW-1:0] id_pc,
  input  logic [DPW-1:0] id_rs1_data,
  input  logic [DPW-1:0] id_rs2_data,
  input  logic [DPW-1:0] id_imm,
  input  logic [RAW-1:0] id_rs1_addr,
  input  logic [RAW-1:0] id_rs2_addr,
  input  logic [RAW-1:0] id_rd_addr,
  input  logic           id_rd_wen,
  input  alu_op_t        id_opcode,
  input  logic           id_a_sel,
  input  logic           id_b_sel,
  input  logic           mem_fwd_wen,
  input  logic [RAW-1:0] mem_fwd_addr,
  input  logic [DPW-1:0] mem_fwd_data,
  input  logic           wb_fwd_wen,
  input  logic [RAW-1:0] wb_fwd_addr,
  input  logic [DPW-1:0] wb_fwd_data,
  input  logic           flush,
  output logic           ex_valid,
  input  logic           ex_ready,
  output logic [DPW-1:0] ex_result,
  output logic [RAW-1:0] ex_rd_addr,
  output logic           ex_rd_wen
);

  logic [DPW-1:0] rs1_fwd, rs2_fwd, opr_a, opr_b, sum, alu_res;
  logic           cout, ovf, lt_s, lt_u, load;
  alu_op_t        add_op;

  logic           valid_q, valid_d;
  logic [DPW-1:0] result_q, result_d;
  logic [RAW-1:0] rd_addr_q, rd_addr_d;
  logic           rd_wen_q, rd_wen_d;

  fwd_mux u_fwd_rs1 (
    .addr(id_rs1_addr), .id_data(id_rs1_data),
    .mem_wen(mem_fwd_wen), .mem_addr(mem_fwd_addr), .mem_data(mem_fwd_data),
    .wb_wen(wb_fwd_wen), .wb_addr(wb_fwd_addr), .wb_data(wb_fwd_data),
    .data(rs1_fwd)
  );

  fwd_mux u_fwd_rs2 (
    .addr(id_rs2_addr), .id_data(id_rs2_data),
    .mem_wen(mem_fwd_wen), .mem_addr(mem_fwd_addr), .mem_data(mem_fwd_data),
    .wb_wen(wb_fwd_wen), .wb_addr(wb_fwd_addr), .wb_data(wb_fwd_data),
    .data(rs2_fwd)
  );

  assign opr_a = (id_a_sel == A_SEL_PC)  ? id_pc  : rs1_fwd;
  assign opr_b = (id_b_sel == B_SEL_IMM) ? id_imm : rs2_fwd;

  assign add_op = ((id_opcode == SUB_OP) || (id_opcode == SLT_OP) ||
                   (id_opcode == SLTU_OP)) ? SUB_OP : ADD_OP;

  adder_sub u_adder_sub (
    .op(add_op), .a(opr_a), .b(opr_b),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  // a - b computed as a + ~b + 1: no carry out means an unsigned borrow
  assign lt_s = sum[DPW-1] ^ ovf;
  assign lt_u = ~cout;

  always_comb begin
    alu_res = '0;
    case (id_opcode)
      ADD_OP, SUB_OP: alu_res = sum;
      SLT_OP:         alu_res = {{(DPW-1){1'b0}}, lt_s};
      SLTU_OP:        alu_res = {{(DPW-1){1'b0}}, lt_u};
      AND_OP:         alu_res = opr_a & opr_b;
      OR_OP:          alu_res = opr_a | opr_b;
      XOR_OP:         alu_res = opr_a ^ opr_b;
      default:        alu_res = '0;
    endcase
  end

  assign id_ready = !valid_q || ex_ready;
  assign load     = id_valid && id_ready;

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    rd_addr_d = rd_addr_q;
    rd_wen_d  = rd_wen_q;
    if (flush) begin
      valid_d  = 1'b0;
      rd_wen_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      result_d  = alu_res;
      rd_addr_d = id_rd_addr;
      rd_wen_d  = id_rd_wen;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      rd_addr_q <= '0;
      rd_wen_q  <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      rd_addr_q <= rd_addr_d;
      rd_wen_q  <= rd_wen_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_result  = result_q;
  assign ex_rd_addr = rd_addr_q;
  assign ex_rd_wen  = rd_wen_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding priority, back-pressure,
// flush, streaming and asynchronous reset.
module tb_ex_stage;
  import rv32i_pkg::*;

  logic           clk = 1'b0;
  logic           arst;
  logic           id_valid, id_ready;
  logic [DPW-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [RAW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic           id_rd_wen;
  alu_op_t        id_opcode;
  logic           id_a_sel, id_b_sel;
  logic           mem_fwd_wen, wb_fwd_wen;
  logic [RAW-1:0] mem_fwd_addr, wb_fwd_addr;
  logic [DPW-1:0] mem_fwd_data, wb_fwd_data;
  logic           flush;
  logic           ex_valid, ex_ready;
  logic [DPW-1:0] ex_result;
  logic [RAW-1:0] ex_rd_addr;
  logic           ex_rd_wen;

  int errs = 0;
  int checks = 0;

  ex_stage dut (
    .clk(clk), .arst(arst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_rd_wen(id_rd_wen), .id_opcode(id_opcode), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .mem_fwd_wen(mem_fwd_wen), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_wen(wb_fwd_wen), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic instr(input alu_op_t op, input logic a_sel, input logic b_sel,
                       input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] rd);
    id_valid    = 1'b1;
    id_opcode   = op;
    id_a_sel    = a_sel;
    id_b_sel    = b_sel;
    id_pc       = pc;
    id_rs1_data = r1;
    id_rs2_data = r2;
    id_imm      = imm;
    id_rs1_addr = a1;
    id_rs2_addr = a2;
    id_rd_addr  = rd;
    id_rd_wen   = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst = 1'b1;
    id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    instr(ADD_OP, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
    id_valid = 1'b0; id_rd_wen = 1'b0;
    mem_fwd_wen = 1'b0; mem_fwd_addr = '0; mem_fwd_data = '0;
    wb_fwd_wen  = 1'b0; wb_fwd_addr  = '0; wb_fwd_data  = '0;
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_ready", {31'd0, id_ready}, 32'd1);
    arst = 1'b0;
    step();

    // basic ops
    instr(SUB_OP, A_SEL_RS1, B_SEL_RS2, 32'h0, 32'd7, 32'd12, 32'h0, 5'd1, 5'd2, 5'd3);
    step();
    chk("sub_res", ex_result, 32'hFFFF_FFFB);
    chk("sub_vld", {31'd0, ex_valid}, 32'd1);
    chk("sub_rd", {27'd0, ex_rd_addr}, 32'd3);
    instr(SLT_OP, A_SEL_RS1, B_SEL_RS2, 32'h0, 32'h8000_0000, 32'd1, 32'h0, 5'd1, 5'd2, 5'd4);
    step();
    chk("slt_res", ex_result, 32'd1);
    instr(SLTU_OP, A_SEL_RS1, B_SEL_RS2, 32'h0, 32'h8000_0000, 32'd1, 32'h0, 5'd1, 5'd2, 5'd4);
    step();
    chk("sltu_res", ex_result, 32'd0);
    instr(AND_OP, A_SEL_RS1, B_SEL_RS2, 32'h0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 5'd1, 5'd2, 5'd4);
    step();
    chk("and_res", ex_result, 32'h00F0_1200);
    instr(OR_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'hF000_0001, 32'h0, 32'h0000_0F00, 5'd1, 5'd2, 5'd4);
    step();
    chk("or_res", ex_result, 32'hF000_0F01);
    instr(XOR_OP, A_SEL_RS1, B_SEL_RS2, 32'h0, 32'hFFFF_0000, 32'hFF00_FF00, 32'h0, 5'd1, 5'd2, 5'd4);
    step();
    chk("xor_res", ex_result, 32'h00FF_FF00);
    instr(alu_op_t'(4'hF), A_SEL_RS1, B_SEL_RS2, 32'h0, 32'd5, 32'd6, 32'h0, 5'd1, 5'd2, 5'd4);
    step();
    chk("bad_op", ex_result, 32'd0);

    // forwarding
    mem_fwd_wen = 1'b1; mem_fwd_addr = 5'd5; mem_fwd_data = 32'h10;
    wb_fwd_wen  = 1'b1; wb_fwd_addr  = 5'd5; wb_fwd_data  = 32'h20;
    instr(ADD_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'h99, 32'h0, 32'h0, 5'd5, 5'd0, 5'd6);
    step();
    chk("fwd_mem", ex_result, 32'h10);
    mem_fwd_addr = 5'd6;
    instr(ADD_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'h99, 32'h0, 32'd1, 5'd5, 5'd0, 5'd6);
    step();
    chk("fwd_wb", ex_result, 32'h21);
    mem_fwd_addr = 5'd0; wb_fwd_addr = 5'd0;
    instr(ADD_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'h55, 32'h0, 32'd3, 5'd0, 5'd0, 5'd6);
    step();
    chk("fwd_x0", ex_result, 32'd3);
    mem_fwd_addr = 5'd2; wb_fwd_wen = 1'b0;
    instr(SUB_OP, A_SEL_RS1, B_SEL_RS2, 32'h0, 32'd100, 32'd1, 32'h0, 5'd1, 5'd2, 5'd6);
    step();
    chk("fwd_rs2", ex_result, 32'd84);
    mem_fwd_wen = 1'b0;

    // back-pressure: slot holds A, B waits, then loads on the drain edge
    instr(ADD_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'd40, 32'h0, 32'd2, 5'd1, 5'd0, 5'd7);
    step();
    chk("bp_a", ex_result, 32'd42);
    ex_ready = 1'b0;
    instr(ADD_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'd50, 32'h0, 32'd5, 5'd1, 5'd0, 5'd8);
    #1;
    chk("bp_rdy0", {31'd0, id_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", ex_result, 32'd42);
      chk("bp_hold_rd", {27'd0, ex_rd_addr}, 32'd7);
      chk("bp_hold_vld", {31'd0, ex_valid}, 32'd1);
      chk("bp_hold_rdy", {31'd0, id_ready}, 32'd0);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_rdy1", {31'd0, id_ready}, 32'd1);
    step();
    chk("bp_b", ex_result, 32'd55);
    chk("bp_b_vld", {31'd0, ex_valid}, 32'd1);

    // flush while accepting
    instr(ADD_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'd1, 32'h0, 32'd1, 5'd1, 5'd0, 5'd9);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_vld", {31'd0, ex_valid}, 32'd0);
    chk("flush_wen", {31'd0, ex_rd_wen}, 32'd0);
    id_valid = 1'b0;
    step();
    chk("flush_idle", {31'd0, ex_valid}, 32'd0);

    // streaming ADDI using pc + imm
    for (int i = 0; i < 8; i++) begin
      instr(ADD_OP, A_SEL_PC, B_SEL_IMM, 32'h100 + 32'(4 * i), 32'hDEAD, 32'h0, 32'(i),
            5'd1, 5'd0, 5'(i + 1));
      step();
      chk("strm_vld", {31'd0, ex_valid}, 32'd1);
      chk("strm_res", ex_result, 32'h100 + 32'(5 * i));
    end
    id_valid = 1'b0;
    step();
    chk("strm_drain", {31'd0, ex_valid}, 32'd0);

    // async reset with the slot full
    ex_ready = 1'b0;
    instr(ADD_OP, A_SEL_RS1, B_SEL_IMM, 32'h0, 32'd9, 32'h0, 32'd9, 5'd1, 5'd0, 5'd10);
    step();
    id_valid = 1'b0;
    chk("ar_full", ex_result, 32'd18);
    #2;
    arst = 1'b1;
    #1;
    chk("ar_vld", {31'd0, ex_valid}, 32'd0);
    chk("ar_res", ex_result, 32'd0);
    chk("ar_rd", {27'd0, ex_rd_addr}, 32'd0);
    chk("ar_wen", {31'd0, ex_rd_wen}, 32'd0);
    chk("ar_rdy", {31'd0, id_ready}, 32'd1);
    arst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
